// File: rtl/pb_timer.sv
// Programmable down-counting timer with prescaler, periodic/one-shot modes,
// sticky expiry/overrun status and a maskable level interrupt.
module pb_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           timer_control,
    input  logic [PRE_WIDTH-1:0] timer_prescale,
    input  logic [CNT_WIDTH-1:0] timer_reload,
    input  logic                 timer_load,
    input  logic                 timer_clear,
    output logic [CNT_WIDTH-1:0] timer_count,
    output logic [7:0]           timer_status,
    output logic                 timer_int
);

    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 armed_q, armed_d;
    logic                 expired_q, expired_d;
    logic                 overrun_q, overrun_d;

    logic ctrl_enable, ctrl_periodic, ctrl_int_en;
    logic run, tick, expire;
    logic ctrl_unused;

    assign ctrl_enable   = timer_control[0];
    assign ctrl_periodic = timer_control[1];
    assign ctrl_int_en   = timer_control[2];
    assign ctrl_unused   = ^timer_control[7:3];

    // Equality compare (not >=) so a lowered prescale lets pre_cnt wrap
    // instead of producing an early tick.
    assign run    = ctrl_enable & armed_q;
    assign tick   = run & (pre_cnt_q == timer_prescale);
    assign expire = tick & (count_q == '0) & ~timer_load;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        count_d   = count_q;
        armed_d   = armed_q;
        expired_d = expired_q;
        overrun_d = overrun_q;

        if (timer_load) begin
            count_d   = timer_reload;
            pre_cnt_d = '0;
            armed_d   = 1'b1;
        end else if (run) begin
            if (tick) begin
                pre_cnt_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - CNT_WIDTH'(1);
                end else begin
                    count_d = timer_reload;
                    if (!ctrl_periodic) begin
                        armed_d = 1'b0;
                    end
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
            end
        end

        // A clear landing on an expiry must not lose the new event.
        if (timer_clear && expire) begin
            expired_d = 1'b1;
        end else if (timer_clear) begin
            expired_d = 1'b0;
            overrun_d = 1'b0;
        end else if (expire) begin
            expired_d = 1'b1;
            overrun_d = overrun_q | expired_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            count_q   <= '0;
            armed_q   <= 1'b0;
            expired_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            count_q   <= count_d;
            armed_q   <= armed_d;
            expired_q <= expired_d;
            overrun_q <= overrun_d;
        end
    end

    assign timer_count  = count_q;
    assign timer_status = {5'b0, armed_q, overrun_q, expired_q};
    assign timer_int    = expired_q & ctrl_int_en;

endmodule

// File: doc/pb_timer.md
Name: pb_timer

Overview:
Programmable 16-bit down-counting timer peripheral for the PicoBlaze SoC. It sits upstream of the interrupt controller, and its timer_int drives one int_src bit. Firmware controls it through the register file: control, prescale and 16-bit reload registers in, plus load/clear write strobes. It gives firmware periodic ticks and one-shot timeouts without polling loops.

Parameters:
CNT_WIDTH, 16, width of the count and reload values (the register file supplies two 8-bit registers).
PRE_WIDTH, 8, width of the prescaler.

Ports:
clk_i  in  1  system clock; the block has one clock.
rst_i  in  1  reset; synchronous and active-high.
timer_control  in  8  FW control register. Bit 0 enable, bit 1 periodic(1)/one-shot(0), bit 2 interrupt enable, bits 7:3 ignored.
timer_prescale  in  PRE_WIDTH  prescale divisor minus 1.
timer_reload  in  CNT_WIDTH  reload value, {reload_hi, reload_lo}.
timer_load  in  1  one-cycle strobe from the register file (write to the load address).
timer_clear  in  1  one-cycle strobe from the register file (write to the status-clear address).
timer_count  out  CNT_WIDTH  live counter value, FW-readable.
timer_status  out  8  bit 0 expired (sticky), bit 1 overrun, bit 2 armed, bits 7:3 zero.
timer_int  out  1  level interrupt request to the interrupt controller.

Behaviour:
- Reset: prescaler 0, count 0, armed 0, expired 0, overrun 0; timer_count 0, timer_status 8'h00, timer_int 0. Reset has priority over all other inputs and aborts any countdown in progress.
- Registers: prescale counter pre_cnt, count, armed, expired, overrun. All outputs are registered or simple decodes of registers.
- Run condition: run = timer_control[0] & armed.
- tick = run & (pre_cnt == timer_prescale).
  - On a tick, pre_cnt returns to 0.
  - On a non-tick cycle with run=1, pre_cnt increments.
  - With run=0, pre_cnt and count hold.
  - Prescale 0 gives a tick every run cycle.
- Count on a tick:
  - count != 0: count decrements by 1.
  - count == 0: expiry event. count reloads from timer_reload.
    - Periodic mode: armed stays 1.
    - One-shot mode: armed clears to 0 and counting stops, with count holding the reloaded value.
- Period: (timer_reload + 1) * (timer_prescale + 1) clk_i cycles, measured from the load strobe to the expiry cycle.
- timer_load: in the next cycle, count = timer_reload, pre_cnt = 0, armed = 1. Load beats a tick or expiry in the same cycle, so no expiry is recorded that cycle. Load does not touch expired or overrun.
- Expiry flags:
  - An expiry event sets expired.
  - If expired is already 1 at the expiry, overrun also sets.
- timer_clear: clears expired and overrun. If clear and expiry coincide, expired ends at 1 and overrun is unchanged, so the new event is not lost.
- timer_int = expired & timer_control[2]. It is a level that stays high until FW clears it. Clearing control bit 2 masks it without losing expired.
- Mode/enable/prescale/reload changes take effect immediately.
  - A new reload value is used only at the next load or expiry.
  - Lowering timer_prescale below the current pre_cnt lets pre_cnt run up to its maximum and wrap to 0 before the next tick; no glitch tick is generated.
- Counter wrap: count never underflows, because it reloads at 0. pre_cnt wraps naturally at its maximum.

Test Plan:
- Reset then idle: timer_status = 8'h00, timer_int = 0, timer_count = 0 for 100 cycles, including with control = 8'h07 and no load.
- Periodic: control 8'h07, prescale 3, reload 4, pulse load. Expected:
  - First expiry 20 cycles after the load strobe.
  - timer_int rises on the same cycle expired sets.
  - Clear pulse drops timer_int.
  - Next expiry follows 20 cycles after the previous one.
- One-shot: control 8'h05, prescale 0, reload 9, load. Expired sets after 10 cycles, armed drops to 0, count holds at 9, and no further expiry occurs in 100 cycles.
- Overrun and simultaneous clear: periodic, reload 1, prescale 0, no clear. After the second expiry, status = 8'h07. A clear asserted on an expiry cycle leaves status bit 0 = 1 and bit 1 unchanged.
- Enable gating: clear control bit 0 mid-count at count = 5. count and pre_cnt freeze. Re-enabling resumes the countdown from 5 with no extra ticks.
- Load priority and reset mid-run: load coincident with an expiry produces no expired set and count = reload. rst_i mid-countdown returns all outputs to their reset values on the next cycle.
